// File: rtl/wb_slave_decoder_n.sv
// Wishbone slave-side decoder: chip-select decode, ACK OR-ing, read-data mux and fault watchdog.
// Define WB_DECODER_TIMEOUT_EN to enable the WAIT-state timeout counter (ERR_STS_o[1] tied low otherwise).
module wb_slave_decoder_n #(
   parameter int unsigned                       NUM_SLAVES         = 4,
   parameter int unsigned                       APERWIDTH          = 17,
   parameter int unsigned                       APERSIZE           = 10,
   parameter logic [NUM_SLAVES*APERWIDTH-1:0]   BASE_ADDRS         = {17'h07000, 17'h06000, 17'h05000, 17'h04000},
   parameter logic [31:0]                       DEFAULT_READ_VALUE = 32'hBAD_FAB_AC,
   parameter int unsigned                       TIMEOUT_WIDTH      = 8,
   parameter int unsigned                       TIMEOUT_CYCLES     = 200
) (
   input  logic                         WBs_CLK_i,
   input  logic                         WBs_RST_i,
   input  logic [APERWIDTH-1:0]         WBs_ADR_i,
   input  logic                         WBs_CYC_i,
   input  logic                         WBs_STB_i,
   input  logic                         WBs_WE_i,
   output logic [31:0]                  WBs_RD_DAT_o,
   output logic                         WBs_ACK_o,
   output logic [NUM_SLAVES-1:0]        SLV_CYC_o,
   input  logic [NUM_SLAVES*32-1:0]     SLV_DAT_i,
   input  logic [NUM_SLAVES-1:0]        SLV_ACK_i,
   input  logic                         ERR_CLR_i,
   output logic [1:0]                   ERR_STS_o,
   output logic [APERWIDTH:0]           ERR_ADR_o,
   output logic                         BUS_ERR_INTR_o
);

   localparam int unsigned FIELD_W = APERWIDTH - APERSIZE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FAULT
   } state_t;

   state_t                  state, state_nxt;
   logic [NUM_SLAVES-1:0]   hit;
   logic                    hit_found;
   logic                    in_fault;
   logic                    req;
   logic                    slv_ack_hit;
   logic                    set_unmapped;
   logic                    fault_entry;
   logic                    sts_unmapped;
   logic                    sts_timeout;
   logic [APERWIDTH:0]      err_adr;
   logic [31:0]             rd_dat;

`ifdef WB_DECODER_TIMEOUT_EN
   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
   logic [TIMEOUT_WIDTH-1:0] cnt, cnt_nxt;
   logic                     set_timeout;
`endif

   // Lowest index wins when bases alias, keeping hit one-hot.
   always_comb begin : decode
      hit       = '0;
      hit_found = 1'b0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (!hit_found &&
             WBs_ADR_i[APERWIDTH-1:APERSIZE] == BASE_ADDRS[i*APERWIDTH+APERSIZE +: FIELD_W]) begin
            hit[i]    = 1'b1;
            hit_found = 1'b1;
         end
      end
   end

   assign in_fault = (state == ST_FAULT);
   assign req      = WBs_CYC_i & WBs_STB_i;

   assign SLV_CYC_o = (WBs_CYC_i && WBs_RST_i && !in_fault) ? hit : '0;

   // Qualifying by SLV_CYC_o masks unselected slaves and stray ACKs outside a cycle.
   assign slv_ack_hit = |(SLV_ACK_i & SLV_CYC_o);
   assign WBs_ACK_o   = WBs_RST_i & (slv_ack_hit | in_fault);

   always_comb begin : rd_mux
      rd_dat = DEFAULT_READ_VALUE;
      if (!in_fault) begin
         for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i]) rd_dat = SLV_DAT_i[i*32 +: 32];
         end
      end
   end

   assign WBs_RD_DAT_o = rd_dat;

   always_comb begin : fsm_next
      state_nxt    = state;
      set_unmapped = 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
      set_timeout  = 1'b0;
      cnt_nxt      = cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (!hit_found) begin
                  state_nxt    = ST_FAULT;
                  set_unmapped = 1'b1;
               end else if (!slv_ack_hit) begin
                  state_nxt = ST_WAIT;
`ifdef WB_DECODER_TIMEOUT_EN
                  cnt_nxt   = TIMEOUT_WIDTH'(1);
`endif
               end
            end
         end
         ST_WAIT: begin
            if (!WBs_CYC_i || slv_ack_hit) begin
               state_nxt = ST_IDLE;
            end
`ifdef WB_DECODER_TIMEOUT_EN
            else if (cnt == TIMEOUT_LIMIT) begin
               state_nxt   = ST_FAULT;
               set_timeout = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         ST_FAULT: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

`ifdef WB_DECODER_TIMEOUT_EN
   assign fault_entry = set_unmapped | set_timeout;
`else
   assign fault_entry = set_unmapped;
`endif

   // A new error in the same cycle as ERR_CLR_i survives the clear.
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_i) begin
         state        <= ST_IDLE;
         sts_unmapped <= 1'b0;
         err_adr      <= '0;
`ifdef WB_DECODER_TIMEOUT_EN
         cnt          <= '0;
`endif
      end else begin
         state        <= state_nxt;
         sts_unmapped <= (sts_unmapped & ~ERR_CLR_i) | set_unmapped;
`ifdef WB_DECODER_TIMEOUT_EN
         cnt          <= cnt_nxt;
`endif
         if (fault_entry) err_adr <= {WBs_WE_i, WBs_ADR_i};
      end
   end

`ifdef WB_DECODER_TIMEOUT_EN
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_i) sts_timeout <= 1'b0;
      else            sts_timeout <= (sts_timeout & ~ERR_CLR_i) | set_timeout;
   end
`else
   assign sts_timeout = 1'b0;
`endif

   assign ERR_STS_o      = {sts_timeout, sts_unmapped};
   assign ERR_ADR_o      = err_adr;
   assign BUS_ERR_INTR_o = sts_timeout | sts_unmapped;

endmodule

// File: tb/tb_wb_slave_decoder_n.sv
// Self-checking bench for wb_slave_decoder_n: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_wb_slave_decoder_n;

   localparam int          NS    = 4;
   localparam int          AW    = 17;
   localparam int          AS    = 10;
   localparam int          TO    = 200;
   localparam int          NEVER = 100000;
   localparam logic [31:0] DEF   = 32'hBADFABAC;
   localparam logic [AW-1:0] BASES [NS] = '{17'h04000, 17'h05000, 17'h06000, 17'h07000};
`ifdef WB_DECODER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [AW-1:0]     adr;
   logic              cyc, stb, we;
   logic [NS*32-1:0]  slv_dat;
   logic [NS-1:0]     slv_ack;
   logic              err_clr;
   logic [31:0]       rd_dat;
   logic              ack;
   logic [NS-1:0]     slv_cyc;
   logic [1:0]        err_sts;
   logic [AW:0]       err_adr;
   logic              intr;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [1:0]  m_sts;
   logic [AW:0] m_adr;

   wb_slave_decoder_n #(
      .NUM_SLAVES         (NS),
      .APERWIDTH          (AW),
      .APERSIZE           (AS),
      .BASE_ADDRS         ({17'h07000, 17'h06000, 17'h05000, 17'h04000}),
      .DEFAULT_READ_VALUE (DEF),
      .TIMEOUT_WIDTH      (8),
      .TIMEOUT_CYCLES     (TO)
   ) dut (
      .WBs_CLK_i      (clk),
      .WBs_RST_i      (rst_n),
      .WBs_ADR_i      (adr),
      .WBs_CYC_i      (cyc),
      .WBs_STB_i      (stb),
      .WBs_WE_i       (we),
      .WBs_RD_DAT_o   (rd_dat),
      .WBs_ACK_o      (ack),
      .SLV_CYC_o      (slv_cyc),
      .SLV_DAT_i      (slv_dat),
      .SLV_ACK_i      (slv_ack),
      .ERR_CLR_i      (err_clr),
      .ERR_STS_o      (err_sts),
      .ERR_ADR_o      (err_adr),
      .BUS_ERR_INTR_o (intr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int decode(input logic [AW-1:0] a);
      for (int i = 0; i < NS; i++) begin
         if ((a >> AS) == (BASES[i] >> AS)) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] slave_word(input int i);
      return slv_dat[i*32 +: 32];
   endfunction

   task automatic randomize_slaves();
      for (int i = 0; i < NS; i++) slv_dat[i*32 +: 32] = $urandom;
      slv_ack = NS'($urandom);
   endtask

   task automatic check_cycle(input string tag, input logic e_ack, input logic [NS-1:0] e_cyc,
                              input logic [31:0] e_rd);
      #1;
      check({tag, ".ack"},     64'(ack),     64'(e_ack));
      check({tag, ".slv_cyc"}, 64'(slv_cyc), 64'(e_cyc));
      check({tag, ".rd_dat"},  64'(rd_dat),  64'(e_rd));
      check({tag, ".err_sts"}, 64'(err_sts), 64'(m_sts));
      check({tag, ".err_adr"}, 64'(err_adr), 64'(m_adr));
      check({tag, ".intr"},    64'(intr),    64'(|m_sts));
   endtask

   task automatic step(input logic [1:0] set, input bit do_rst);
      @(posedge clk);
      if (do_rst) begin
         m_sts = '0;
         m_adr = '0;
      end else begin
         if (set != 2'b00) m_adr = {we, adr};
         m_sts = (err_clr ? 2'b00 : m_sts) | set;
      end
      #1;
   endtask

   task automatic idle_cycle(input logic [AW-1:0] a, input logic [NS-1:0] acks, input bit clr);
      int t;
      logic [31:0] e_rd;
      cyc = 1'b0; stb = 1'b0; adr = a; we = 1'($urandom);
      randomize_slaves();
      slv_ack = acks;
      err_clr = clr;
      t = decode(a);
      e_rd = DEF;
      if (t >= 0) e_rd = slave_word(t);
      check_cycle("idle", 1'b0, '0, e_rd);
      step(2'b00, 1'b0);
      err_clr = 1'b0;
   endtask

   // clr_at: -1 never, -2 random per cycle, otherwise the cycle index to pulse ERR_CLR_i.
   task automatic run_txn(input string tag, input logic [AW-1:0] a, input bit w, input int ack_dly,
                          input int abort_at, input int rst_at, input int clr_at);
      int          t;
      bit          done, flt, do_rst, abrt;
      logic [1:0]  set;
      logic        e_ack;
      logic [NS-1:0] e_cyc;
      logic [31:0] e_rd;
      t = decode(a);
      adr = a; we = w; cyc = 1'b1; stb = 1'b1;
      done = 1'b0;
      for (int c = 0; c <= TO + 300 && !done; c++) begin
         randomize_slaves();
         if (t >= 0) slv_ack[t] = (c == ack_dly);
         err_clr = (clr_at == -2) ? ($urandom_range(0, 9) == 0) : (clr_at == c);
         do_rst  = (c == rst_at);
         rst_n   = !do_rst;
         abrt    = (c == abort_at);
         if (abrt) begin cyc = 1'b0; stb = 1'b0; end
         set = 2'b00; e_ack = 1'b0; e_cyc = '0; e_rd = DEF;
         flt = (t < 0 && c == 1) || (TO_EN && t >= 0 && c == TO + 1);
         if (do_rst || abrt) begin
            if (t >= 0) e_rd = slave_word(t);
            done = 1'b1;
         end else if (flt) begin
            e_ack = 1'b1;
            done  = 1'b1;
         end else if (t < 0) begin
            set = 2'b01;
         end else begin
            e_cyc = NS'(1) << t;
            e_rd  = slave_word(t);
            e_ack = (c == ack_dly);
            done  = e_ack;
            if (TO_EN && c == TO && !e_ack) set = 2'b10;
         end
         check_cycle(tag, e_ack, e_cyc, e_rd);
         step(set, do_rst);
      end
      check({tag, ".completed"}, 64'(done), 64'(1));
      cyc = 1'b0; stb = 1'b0; rst_n = 1'b1; err_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
      slv_dat = '0; slv_ack = '0; err_clr = 1'b0;
      m_sts = '0; m_adr = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset held with an active request and all slaves acking: everything stays quiet.
      cyc = 1'b1; stb = 1'b1; adr = 17'h04000;
      randomize_slaves();
      slv_ack = '1;
      check_cycle("reset", 1'b0, '0, slave_word(0));
      step(2'b00, 1'b1);
      rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;

      run_txn("rd_s0",     17'h04010, 1'b0, 3,     -1, -1, -1);
      run_txn("unmapped",  17'h0A000, 1'b0, NEVER, -1, -1, -1);
`ifdef WB_DECODER_TIMEOUT_EN
      run_txn("timeout_wr", 17'h05004, 1'b1, TO + 1, -1, -1, -1);
      idle_cycle(17'h05004, 4'b0010, 1'b0);
      run_txn("ack_at_limit", 17'h06008, 1'b0, TO, -1, -1, -1);
`else
      run_txn("hang_wr",   17'h05004, 1'b1, NEVER, 250, -1, -1);
`endif
      run_txn("clr_vs_set", 17'h0A000, 1'b0, NEVER, -1, -1, 0);
      idle_cycle(17'h00000, '0, 1'b1);
      idle_cycle(17'h00000, '0, 1'b0);
      run_txn("unmapped_wr", 17'h1F123, 1'b1, NEVER, -1, -1, -1);
      run_txn("rst_wait",  17'h06000, 1'b0, NEVER, -1, 50, -1);
      idle_cycle(17'h00000, '0, 1'b0);
      run_txn("after_rst", 17'h04000, 1'b0, 2,     -1, -1, -1);
      run_txn("abort",     17'h07000, 1'b0, NEVER, 10, -1, -1);
      run_txn("edge_hi",   17'h043FF, 1'b0, 1,     -1, -1, -1);
      run_txn("edge_top",  17'h07FFF, 1'b1, 0,     -1, -1, -1);
      run_txn("edge_over", 17'h08000, 1'b0, NEVER, -1, -1, -1);
      run_txn("edge_under",17'h03FFF, 1'b1, NEVER, -1, -1, -1);

      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         int ad, ab, s;
         if ($urandom_range(0, 9) < 7) begin
            s = $urandom_range(0, NS - 1);
            a = BASES[s] + AW'($urandom_range(0, 1023));
         end else begin
            a = AW'($urandom);
         end
         ad = $urandom_range(0, 6);
`ifdef WB_DECODER_TIMEOUT_EN
         if ($urandom_range(0, 9) == 0) ad = NEVER;
`endif
         ab = -1;
         if (ad >= 1 && $urandom_range(0, 5) == 0) ab = $urandom_range(1, (ad > 6) ? 30 : ad);
         run_txn("rnd", a, 1'($urandom_range(0, 1)), ad, ab, -1, -2);
         repeat ($urandom_range(1, 2)) idle_cycle(AW'($urandom), NS'($urandom), $urandom_range(0, 7) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
